// File: rtl/dual_issue_scheduler.sv
// Dual-issue controller: takes one instruction pair per fetch handshake and
// issues it on both lanes, split over two cycles in program order, or after
// load-use bubbles, driving lane enables and freezes for the two datapaths.
module dual_issue_scheduler #(
    parameter int          LOAD_USE_BUBBLES = 1,
    parameter logic [31:0] NOP_INSTR        = 32'h0000_0013,
    parameter int          BCNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst_pin,
    input  logic              fetch_valid,
    input  logic [31:0]       instruction0,
    input  logic [31:0]       instruction1,
    output logic              fetch_ready,
    input  logic              flush,
    input  logic              hold,
    output logic [31:0]       issue_ins0,
    output logic [31:0]       issue_ins1,
    output logic              datapath_1_enable,
    output logic              datapath_2_enable,
    output logic              freeze1,
    output logic              freeze2,
    output logic [BCNT_W-1:0] bubble_count
);

    localparam int   BW    = (LOAD_USE_BUBBLES > 1) ? $clog2(LOAD_USE_BUBBLES) : 1;
    localparam logic MULTI = (LOAD_USE_BUBBLES > 1);

    localparam logic [6:0] OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111,
                           OP_JAL   = 7'b1101111, OP_JALR  = 7'b1100111,
                           OP_BR    = 7'b1100011, OP_LOAD  = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_REG   = 7'b0110011;

    typedef enum logic [1:0] {S_PAIR, S_SECOND, S_BUBBLE} state_t;

    state_t      state, state_nxt;
    logic [BW-1:0] bub_cnt, bub_nxt;
    logic        ret_second, ret_nxt;
    logic        pv, last_load_valid;
    logic [4:0]  last_load_rd;
    logic [31:0] p0, p1;
    logic        iss1, iss2, pair_done, load_use, split, active, accept;

    // Destination register, or x0 when the instruction writes nothing.
    function automatic logic [4:0] dest(input logic [31:0] i);
        return (i[6:0] == OP_STORE || i[6:0] == OP_BR) ? 5'd0 : i[11:7];
    endfunction

    // True if instruction i reads register r (x0 never counts).
    function automatic logic reads(input logic [31:0] i, input logic [4:0] r);
        logic u1, u2;
        u1 = !(i[6:0] == OP_LUI || i[6:0] == OP_AUIPC || i[6:0] == OP_JAL);
        u2 = (i[6:0] == OP_REG || i[6:0] == OP_STORE || i[6:0] == OP_BR);
        return (r != 5'd0) && ((u1 && i[19:15] == r) || (u2 && i[24:20] == r));
    endfunction

    function automatic logic is_mem(input logic [31:0] i);
        return i[6:0] == OP_LOAD || i[6:0] == OP_STORE;
    endfunction

    function automatic logic is_ctrl(input logic [31:0] i);
        return i[6:0] == OP_BR || i[6:0] == OP_JAL || i[6:0] == OP_JALR;
    endfunction

    // Hazard detection and the per-cycle issue decision before stall gating.
    always_comb begin
        logic lu0, lu1;
        lu0      = last_load_valid && reads(p0, last_load_rd);
        lu1      = last_load_valid && reads(p1, last_load_rd);
        load_use = pv && ((state == S_PAIR && (lu0 || lu1)) || (state == S_SECOND && lu1));
        split    = reads(p1, dest(p0))
                || (dest(p0) != 5'd0 && dest(p0) == dest(p1))
                || (is_mem(p0) && is_mem(p1))
                || is_ctrl(p0);
        iss1      = 1'b0;
        iss2      = 1'b0;
        pair_done = 1'b0;
        if (pv && !load_use) begin
            if (state == S_PAIR) begin
                iss1      = 1'b1;
                iss2      = !split;
                pair_done = !split;
            end else if (state == S_SECOND) begin
                iss2      = 1'b1;
                pair_done = 1'b1;
            end
        end
        active = !hold && !flush;
        accept = fetch_valid && fetch_ready;
    end

    // Outputs: enables gated by stall/redirect, idle lanes carry NOP.
    always_comb begin
        datapath_1_enable = iss1 && active;
        datapath_2_enable = iss2 && active;
        freeze1           = !datapath_1_enable;
        freeze2           = !datapath_2_enable;
        issue_ins0        = datapath_1_enable ? p0 : NOP_INSTR;
        issue_ins1        = datapath_2_enable ? p1 : NOP_INSTR;
        fetch_ready       = rst_pin && active && (!pv || pair_done);
    end

    // Next-state logic: split sequencing and load-use bubble countdown.
    always_comb begin
        state_nxt = state;
        bub_nxt   = bub_cnt;
        ret_nxt   = ret_second;
        if (flush) begin
            state_nxt = S_PAIR;
            bub_nxt   = '0;
        end else if (!hold) begin
            if (accept) begin
                state_nxt = S_PAIR;
            end else begin
                case (state)
                    S_PAIR, S_SECOND: begin
                        if (load_use) begin
                            if (MULTI) begin
                                state_nxt = S_BUBBLE;
                                bub_nxt   = BW'(LOAD_USE_BUBBLES - 1);
                                ret_nxt   = (state == S_SECOND);
                            end
                        end else if (state == S_PAIR && iss1 && !iss2) begin
                            state_nxt = S_SECOND;
                        end else if (pair_done) begin
                            state_nxt = S_PAIR;
                        end
                    end
                    default: begin
                        bub_nxt = bub_cnt - BW'(1);
                        if (bub_cnt <= BW'(1)) begin
                            state_nxt = ret_second ? S_SECOND : S_PAIR;
                            bub_nxt   = '0;
                        end
                    end
                endcase
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_pin) begin
        if (!rst_pin) begin
            state      <= S_PAIR;
            bub_cnt    <= '0;
            ret_second <= 1'b0;
        end else begin
            state      <= state_nxt;
            bub_cnt    <= bub_nxt;
            ret_second <= ret_nxt;
        end
    end

    // Pair buffer, load tracking and bubble statistics.
    always_ff @(posedge clk or negedge rst_pin) begin
        if (!rst_pin) begin
            pv              <= 1'b0;
            p0              <= NOP_INSTR;
            p1              <= NOP_INSTR;
            last_load_valid <= 1'b0;
            last_load_rd    <= 5'd0;
            bubble_count    <= '0;
        end else if (flush) begin
            pv              <= 1'b0;
            last_load_valid <= 1'b0;
        end else if (!hold) begin
            if (accept) begin
                pv <= 1'b1;
                p0 <= instruction0;
                p1 <= instruction1;
            end else if (pair_done) begin
                pv <= 1'b0;
            end
            last_load_valid <= (iss1 && p0[6:0] == OP_LOAD) || (iss2 && p1[6:0] == OP_LOAD);
            if (iss2 && p1[6:0] == OP_LOAD)
                last_load_rd <= p1[11:7];
            else if (iss1 && p0[6:0] == OP_LOAD)
                last_load_rd <= p0[11:7];
            if (pv && !iss1 && !iss2 && bubble_count != '1)
                bubble_count <= bubble_count + BCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Bench for dual_issue_scheduler: per-cycle vector table fed through an
// expected-result queue, plus reset and mid-operation reset sequences.
module tb_dual_issue_scheduler;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] A   = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] B   = 32'h0070_0113; // addi x2,x0,7
    localparam logic [31:0] C   = 32'h0010_81b3; // add x3,x1,x1
    localparam logic [31:0] L   = 32'h0000_2283; // lw x5,0(x0)
    localparam logic [31:0] D   = 32'h0010_0313; // addi x6,x0,1
    localparam logic [31:0] E   = 32'h0002_83b3; // add x7,x5,x0
    localparam logic [31:0] S   = 32'h0060_2023; // sw x6,0(x0)
    localparam logic [31:0] F   = 32'h0002_8433; // add x8,x5,x0

    logic        clk = 1'b0;
    logic        rst_pin = 1'b0;
    logic        fetch_valid = 1'b0, flush = 1'b0, hold = 1'b0;
    logic [31:0] instruction0 = NOP, instruction1 = NOP;
    logic        fetch_ready, datapath_1_enable, datapath_2_enable, freeze1, freeze2;
    logic [31:0] issue_ins0, issue_ins1;
    logic [15:0] bubble_count;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic        fv, fl, hd;
        logic [31:0] i0, i1;
        logic        en1, en2, fr;
        logic [31:0] o0, o1;
        logic [15:0] bc;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    dual_issue_scheduler dut (
        .clk(clk), .rst_pin(rst_pin), .fetch_valid(fetch_valid),
        .instruction0(instruction0), .instruction1(instruction1),
        .fetch_ready(fetch_ready), .flush(flush), .hold(hold),
        .issue_ins0(issue_ins0), .issue_ins1(issue_ins1),
        .datapath_1_enable(datapath_1_enable), .datapath_2_enable(datapath_2_enable),
        .freeze1(freeze1), .freeze2(freeze2), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic add(input logic fv, input logic [31:0] i0, input logic [31:0] i1,
                       input logic fl, input logic hd, input logic en1, input logic en2,
                       input logic [31:0] o0, input logic [31:0] o1, input logic fr,
                       input logic [15:0] bc);
        vec_t v;
        v.fv = fv; v.i0 = i0; v.i1 = i1; v.fl = fl; v.hd = hd;
        v.en1 = en1; v.en2 = en2; v.o0 = o0; v.o1 = o1; v.fr = fr; v.bc = bc;
        tbl.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        chk({tag, ".en1"}, 32'(datapath_1_enable), 32'(e.en1));
        chk({tag, ".en2"}, 32'(datapath_2_enable), 32'(e.en2));
        chk({tag, ".frz1"}, 32'(freeze1), 32'(!e.en1));
        chk({tag, ".frz2"}, 32'(freeze2), 32'(!e.en2));
        chk({tag, ".ins0"}, issue_ins0, e.o0);
        chk({tag, ".ins1"}, issue_ins1, e.o1);
        chk({tag, ".ready"}, 32'(fetch_ready), 32'(e.fr));
        chk({tag, ".bcnt"}, 32'(bubble_count), 32'(e.bc));
    endtask

    initial begin
        vec_t cur;
        vec_t rst_exp;

        //   fv  i0   i1   fl hd  en1 en2 o0   o1   fr  bc
        // dual-issue independent pair
        add(1, A,   B,   0, 0,  0,  0,  NOP, NOP, 1,  0);
        add(0, NOP, NOP, 0, 0,  1,  1,  A,   B,   1,  0);
        // RAW inside pair -> split
        add(1, A,   C,   0, 0,  0,  0,  NOP, NOP, 1,  0);
        add(0, NOP, NOP, 0, 0,  1,  0,  A,   NOP, 0,  0);
        add(0, NOP, NOP, 0, 0,  0,  1,  NOP, C,   1,  0);
        // load dual, then consumer pair accepted back-to-back -> one bubble
        add(1, L,   D,   0, 0,  0,  0,  NOP, NOP, 1,  0);
        add(1, E,   NOP, 0, 0,  1,  1,  L,   D,   1,  0);
        add(0, NOP, NOP, 0, 0,  0,  0,  NOP, NOP, 0,  0);
        add(0, NOP, NOP, 0, 0,  1,  1,  E,   NOP, 1,  1);
        // two memory ops split, flush kills the second half
        add(1, L,   S,   0, 0,  0,  0,  NOP, NOP, 1,  1);
        add(0, NOP, NOP, 0, 0,  1,  0,  L,   NOP, 0,  1);
        add(0, NOP, NOP, 1, 0,  0,  0,  NOP, NOP, 0,  1);
        add(0, NOP, NOP, 0, 0,  0,  0,  NOP, NOP, 1,  1);
        // split with 3-cycle hold between halves; offered pair ignored
        add(1, A,   C,   0, 0,  0,  0,  NOP, NOP, 1,  1);
        add(0, NOP, NOP, 0, 0,  1,  0,  A,   NOP, 0,  1);
        add(1, B,   D,   0, 1,  0,  0,  NOP, NOP, 0,  1);
        add(0, NOP, NOP, 0, 1,  0,  0,  NOP, NOP, 0,  1);
        add(0, NOP, NOP, 0, 1,  0,  0,  NOP, NOP, 0,  1);
        add(0, NOP, NOP, 0, 0,  0,  1,  NOP, C,   1,  1);
        // flush beats an offered pair
        add(1, A,   B,   1, 0,  0,  0,  NOP, NOP, 0,  1);
        add(0, NOP, NOP, 0, 0,  0,  0,  NOP, NOP, 1,  1);
        // load in lane 1, dependent second half stalls once
        add(1, L,   F,   0, 0,  0,  0,  NOP, NOP, 1,  1);
        add(0, NOP, NOP, 0, 0,  1,  0,  L,   NOP, 0,  1);
        add(0, NOP, NOP, 0, 0,  0,  0,  NOP, NOP, 0,  1);
        add(0, NOP, NOP, 0, 0,  0,  1,  NOP, F,   1,  2);

        rst_exp.en1 = 0; rst_exp.en2 = 0; rst_exp.o0 = NOP; rst_exp.o1 = NOP;
        rst_exp.fr = 0; rst_exp.bc = 0;
        rst_exp.fv = 0; rst_exp.fl = 0; rst_exp.hd = 0; rst_exp.i0 = NOP; rst_exp.i1 = NOP;

        // reset state
        repeat (2) @(negedge clk);
        check_outputs("reset", rst_exp);
        #1 rst_pin = 1'b1;
        #1 chk("release.ready", 32'(fetch_ready), 32'd1);

        // table, through the expected-result queue
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            fetch_valid  = tbl[i].fv;
            instruction0 = tbl[i].i0;
            instruction1 = tbl[i].i1;
            flush        = tbl[i].fl;
            hold         = tbl[i].hd;
            exp_q.push_back(tbl[i]);
            @(negedge clk);
            cur = exp_q.pop_front();
            check_outputs($sformatf("step%0d", i), cur);
        end

        // reset in the middle of a split pair
        @(posedge clk);
        #1 fetch_valid = 1'b1; instruction0 = A; instruction1 = C; flush = 1'b0; hold = 1'b0;
        @(posedge clk);
        #1 fetch_valid = 1'b0;
        @(negedge clk);
        chk("midrst.pre_en1", 32'(datapath_1_enable), 32'd1);
        #1 rst_pin = 1'b0;
        #1 check_outputs("midrst", rst_exp);
        @(negedge clk);
        #1 rst_pin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst.after_en2", 32'(datapath_2_enable), 32'd0);
        chk("midrst.after_ready", 32'(fetch_ready), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
